run_sequencer: RTL and testbench

- Top-level run controller for the multi-core processor system. Sequences one complete run: instruction load over UART, data load over UART, processor execution, then result unload to the UART transmitter.
- Owns the INS_RAM and DATA_RAM ports and muxes them between the UART loaders, the processor and its own unload engine.
- Sits between the UART receive/transmit blocks, multi_core_processor, INS_RAM and DATA_RAM.

---
 rtl/run_sequencer_if.sv | 37 +++
 rtl/run_sequencer.sv | 170 +++++++++++++++++
 tb/tb_run_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_sequencer_if.sv
// Memory and transmitter bus owned by run_sequencer: INS_RAM port,
// DATA_RAM port (with its read data) and the result word handshake.
interface run_sequencer_if #(
   parameter int INS_WIDTH           = 8,
   parameter int INS_MEM_ADDR_WIDTH  = 8,
   parameter int DATA_MEM_WIDTH      = 12,
   parameter int DATA_MEM_ADDR_WIDTH = 12
);
   logic                           insMemWrEn;
   logic [INS_MEM_ADDR_WIDTH-1:0]  insMemAddr;
   logic [INS_WIDTH-1:0]           insMemIn;
   logic                           dataMemWrEn;
   logic [DATA_MEM_ADDR_WIDTH-1:0] dataMemAddr;
   logic [DATA_MEM_WIDTH-1:0]      dataMemIn;
   logic [DATA_MEM_WIDTH-1:0]      dataMemOut;
   logic                           tx_valid;
   logic [DATA_MEM_WIDTH-1:0]      tx_data;
   logic                           tx_ready;

   // Sequencer side: drives both RAM ports and the transmitter word.
   modport master (
      output insMemWrEn, insMemAddr, insMemIn,
      output dataMemWrEn, dataMemAddr, dataMemIn,
      input  dataMemOut,
      output tx_valid, tx_data,
      input  tx_ready
   );

   // RAM / transmitter side.
   modport slave (
      input  insMemWrEn, insMemAddr, insMemIn,
      input  dataMemWrEn, dataMemAddr, dataMemIn,
      output dataMemOut,
      input  tx_valid, tx_data,
      output tx_ready
   );
endinterface

// File: rtl/run_sequencer.sv
// Run controller: instruction load, data load, processor execution, then
// result unload to the UART transmitter. Muxes INS_RAM / DATA_RAM between
// the UART loaders, the processor and the internal unload engine.
module run_sequencer #(
   parameter int INS_WIDTH           = 8,
   parameter int INS_MEM_ADDR_WIDTH  = 8,
   parameter int DATA_MEM_WIDTH      = 12,
   parameter int DATA_MEM_ADDR_WIDTH = 12
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           startN,
   input  logic                           uart_ins_wrEn,
   input  logic [INS_MEM_ADDR_WIDTH-1:0]  uart_ins_addr,
   input  logic [INS_WIDTH-1:0]           uart_ins_data,
   input  logic                           uart_ins_done,
   input  logic                           uart_data_wrEn,
   input  logic [DATA_MEM_ADDR_WIDTH-1:0] uart_data_addr,
   input  logic [DATA_MEM_WIDTH-1:0]      uart_data_in,
   input  logic                           uart_data_done,
   input  logic                           proc_dataMemWrEn,
   input  logic [DATA_MEM_ADDR_WIDTH-1:0] proc_dataMemAddr,
   input  logic [DATA_MEM_WIDTH-1:0]      proc_dataOut,
   input  logic [INS_MEM_ADDR_WIDTH-1:0]  proc_insMemAddr,
   input  logic                           proc_done,
   input  logic [DATA_MEM_ADDR_WIDTH-1:0] result_base,
   input  logic [DATA_MEM_ADDR_WIDTH-1:0] result_count,
   run_sequencer_if.master                bus,
   output logic                           proc_startN,
   output logic [2:0]                     state,
   output logic                           run_done
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      INS_LOAD   = 3'd1,
      DATA_LOAD  = 3'd2,
      PROC_START = 3'd3,
      PROC_EXEC  = 3'd4,
      UNLOAD     = 3'd5,
      FINISH     = 3'd6
   } stateT;

   typedef enum logic [1:0] {
      PH_RD   = 2'd0,
      PH_WAIT = 2'd1,
      PH_SEND = 2'd2
   } phaseT;

   localparam logic [DATA_MEM_ADDR_WIDTH-1:0] ONE = 1;

   stateT                          curState;
   stateT                          nextState;
   phaseT                          phase;
   logic [DATA_MEM_ADDR_WIDTH-1:0] idx;
   logic [DATA_MEM_ADDR_WIDTH-1:0] baseReg;
   logic [DATA_MEM_ADDR_WIDTH-1:0] countReg;
   logic                           txValid;
   logic [DATA_MEM_WIDTH-1:0]      txData;
   logic                           lastAccept;

   assign lastAccept = (phase == PH_SEND) && txValid && bus.tx_ready &&
                       (idx == countReg - ONE);

   // State register; proc_startN is registered from the next state so it is
   // low for exactly the one PROC_START cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         curState    <= IDLE;
         proc_startN <= 1'b1;
      end else begin
         curState    <= nextState;
         proc_startN <= (nextState != PROC_START);
      end
   end

   // Next-state logic; done pulses and startN outside their states are ignored.
   always_comb begin
      nextState = curState;
      case (curState)
         IDLE:       if (!startN) nextState = INS_LOAD;
         INS_LOAD:   if (uart_ins_done) nextState = DATA_LOAD;
         DATA_LOAD:  if (uart_data_done) nextState = PROC_START;
         PROC_START: nextState = PROC_EXEC;
         PROC_EXEC:  if (proc_done) nextState = (result_count == '0) ? FINISH : UNLOAD;
         UNLOAD:     if (lastAccept) nextState = FINISH;
         FINISH:     if (!startN) nextState = INS_LOAD;
         default:    nextState = IDLE;
      endcase
   end

   // Unload engine: latch base/count on entry, then RD -> WAIT -> SEND per word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase    <= PH_RD;
         idx      <= '0;
         baseReg  <= '0;
         countReg <= '0;
         txValid  <= 1'b0;
         txData   <= '0;
      end else if (curState == PROC_EXEC && nextState == UNLOAD) begin
         baseReg  <= result_base;
         countReg <= result_count;
         idx      <= '0;
         phase    <= PH_RD;
         txValid  <= 1'b0;
      end else if (curState == UNLOAD) begin
         case (phase)
            PH_RD:   phase <= PH_WAIT;
            PH_WAIT: begin
               txData  <= bus.dataMemOut;
               txValid <= 1'b1;
               phase   <= PH_SEND;
            end
            PH_SEND: begin
               if (txValid && bus.tx_ready) begin
                  txValid <= 1'b0;
                  idx     <= idx + ONE;
                  phase   <= PH_RD;
               end
            end
            default: phase <= PH_RD;
         endcase
      end
   end

   // RAM port mux selected purely by the current state.
   always_comb begin
      bus.insMemWrEn  = 1'b0;
      bus.insMemAddr  = '0;
      bus.insMemIn    = '0;
      bus.dataMemWrEn = 1'b0;
      bus.dataMemAddr = '0;
      bus.dataMemIn   = '0;
      case (curState)
         INS_LOAD: begin
            bus.insMemWrEn = uart_ins_wrEn;
            bus.insMemAddr = uart_ins_addr;
            bus.insMemIn   = uart_ins_data;
         end
         DATA_LOAD: begin
            bus.dataMemWrEn = uart_data_wrEn;
            bus.dataMemAddr = uart_data_addr;
            bus.dataMemIn   = uart_data_in;
         end
         PROC_START: begin
            bus.insMemAddr  = proc_insMemAddr;
            bus.dataMemAddr = proc_dataMemAddr;
            bus.dataMemIn   = proc_dataOut;
         end
         PROC_EXEC: begin
            bus.insMemAddr  = proc_insMemAddr;
            bus.dataMemWrEn = proc_dataMemWrEn;
            bus.dataMemAddr = proc_dataMemAddr;
            bus.dataMemIn   = proc_dataOut;
         end
         UNLOAD: begin
            bus.dataMemAddr = baseReg + idx;
         end
         default: begin
         end
      endcase
   end

   assign bus.tx_valid = txValid;
   assign bus.tx_data  = txData;
   assign state        = curState;
   assign run_done     = (curState == FINISH);

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: behavioural INS_RAM/DATA_RAM, a reference copy of
// data memory, and a queue of expected transmitted words.
module tb_run_sequencer;

   logic        clk;
   logic        rst;
   logic        startN;
   logic        uart_ins_wrEn;
   logic [7:0]  uart_ins_addr;
   logic [7:0]  uart_ins_data;
   logic        uart_ins_done;
   logic        uart_data_wrEn;
   logic [11:0] uart_data_addr;
   logic [11:0] uart_data_in;
   logic        uart_data_done;
   logic        proc_dataMemWrEn;
   logic [11:0] proc_dataMemAddr;
   logic [11:0] proc_dataOut;
   logic [7:0]  proc_insMemAddr;
   logic        proc_done;
   logic [11:0] result_base;
   logic [11:0] result_count;
   logic        proc_startN;
   logic [2:0]  state;
   logic        run_done;

   run_sequencer_if #(
      .INS_WIDTH(8), .INS_MEM_ADDR_WIDTH(8),
      .DATA_MEM_WIDTH(12), .DATA_MEM_ADDR_WIDTH(12)
   ) busIf ();

   run_sequencer #(
      .INS_WIDTH(8), .INS_MEM_ADDR_WIDTH(8),
      .DATA_MEM_WIDTH(12), .DATA_MEM_ADDR_WIDTH(12)
   ) dut (
      .clk(clk), .rst(rst), .startN(startN),
      .uart_ins_wrEn(uart_ins_wrEn), .uart_ins_addr(uart_ins_addr),
      .uart_ins_data(uart_ins_data), .uart_ins_done(uart_ins_done),
      .uart_data_wrEn(uart_data_wrEn), .uart_data_addr(uart_data_addr),
      .uart_data_in(uart_data_in), .uart_data_done(uart_data_done),
      .proc_dataMemWrEn(proc_dataMemWrEn), .proc_dataMemAddr(proc_dataMemAddr),
      .proc_dataOut(proc_dataOut), .proc_insMemAddr(proc_insMemAddr),
      .proc_done(proc_done), .result_base(result_base), .result_count(result_count),
      .bus(busIf), .proc_startN(proc_startN), .state(state), .run_done(run_done)
   );

   logic [7:0]  insRam  [256];
   logic [11:0] dataRam [4096];
   logic [11:0] refMem  [4096];
   logic [11:0] expQ    [$];
   int          nChecks;
   int          nPass;
   int          pstLow;
   logic        txSeen;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Behavioural RAMs with one-cycle registered read.
   always @(posedge clk) begin
      if (busIf.insMemWrEn) insRam[busIf.insMemAddr] <= busIf.insMemIn;
      if (busIf.dataMemWrEn) dataRam[busIf.dataMemAddr] <= busIf.dataMemIn;
      busIf.dataMemOut <= dataRam[busIf.dataMemAddr];
   end

   // Monitor: scoreboard on handshakes, RAM ownership, start-pulse width.
   always @(negedge clk) begin
      if (!rst) begin
         if (busIf.tx_valid) txSeen = 1'b1;
         if (!proc_startN) pstLow++;
         if (state != 3'd2 && state != 3'd4) checkVal("dwr_owner", 32'(busIf.dataMemWrEn), 32'd0);
         if (state != 3'd1) checkVal("iwr_owner", 32'(busIf.insMemWrEn), 32'd0);
         if (busIf.tx_valid && busIf.tx_ready) begin
            if (expQ.size() == 0) checkVal("tx_extra", 32'd1, 32'd0);
            else checkVal("tx_word", 32'(busIf.tx_data), 32'(expQ.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doStart();
      pstLow = 0;
      txSeen = 1'b0;
      startN = 1'b0;
      tick();
      startN = 1'b1;
      checkVal("start_ins_load", 32'(state), 32'd1);
   endtask

   task automatic insWrite(input logic [7:0] a, input logic [7:0] d);
      uart_ins_wrEn = 1'b1; uart_ins_addr = a; uart_ins_data = d;
      tick();
      uart_ins_wrEn = 1'b0;
   endtask

   task automatic insDone();
      uart_ins_done = 1'b1;
      tick();
      uart_ins_done = 1'b0;
      checkVal("to_data_load", 32'(state), 32'd2);
   endtask

   task automatic dataWrite(input logic [11:0] a, input logic [11:0] d);
      uart_data_wrEn = 1'b1; uart_data_addr = a; uart_data_in = d;
      refMem[a] = d;
      tick();
      uart_data_wrEn = 1'b0;
   endtask

   task automatic dataDone();
      uart_data_done = 1'b1;
      tick();
      uart_data_done = 1'b0;
   endtask

   // Processor phase: start pulse, execution, optional write/stray start, done.
   task automatic procPhase(input logic [11:0] base, input logic [11:0] cnt, input int cycles,
                            input bit doWrite, input bit doStray);
      logic [11:0] a;
      checkVal("proc_start_state", 32'(state), 32'd3);
      checkVal("proc_startN_low", 32'(proc_startN), 32'd0);
      tick();
      checkVal("proc_exec_state", 32'(state), 32'd4);
      proc_insMemAddr = 8'h42;
      for (int c = 0; c < cycles; c++) begin
         if (doWrite && c == 2) begin
            proc_dataMemWrEn = 1'b1; proc_dataMemAddr = 12'h00A; proc_dataOut = 12'h5A5;
            refMem[12'h00A] = 12'h5A5;
         end
         if (doStray && c == 4) startN = 1'b0;
         tick();
         proc_dataMemWrEn = 1'b0;
         startN = 1'b1;
         if (c == 5) begin
            checkVal("exec_hold", 32'(state), 32'd4);
            checkVal("exec_ins_addr", 32'(busIf.insMemAddr), 32'h42);
         end
      end
      result_base = base;
      result_count = cnt;
      for (int i = 0; i < int'(cnt); i++) begin
         a = base + 12'(i);
         expQ.push_back(refMem[a]);
      end
      proc_done = 1'b1;
      tick();
      proc_done = 1'b0;
   endtask

   task automatic waitTxValid();
      for (int k = 0; k < 50 && !busIf.tx_valid; k++) tick();
      checkVal("tx_valid_wait", 32'(busIf.tx_valid), 32'd1);
   endtask

   task automatic waitFinish();
      for (int k = 0; k < 200 && state != 3'd6; k++) tick();
      checkVal("finish_state", 32'(state), 32'd6);
      checkVal("run_done", 32'(run_done), 32'd1);
      checkVal("start_pulse_cycles", 32'(pstLow), 32'd1);
      checkVal("queue_drained", 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      nChecks = 0; nPass = 0; pstLow = 0; txSeen = 1'b0;
      foreach (insRam[i]) insRam[i] = '0;
      foreach (dataRam[i]) dataRam[i] = '0;
      foreach (refMem[i]) refMem[i] = '0;
      rst = 1'b1; startN = 1'b1;
      uart_ins_wrEn = 1'b0; uart_ins_addr = '0; uart_ins_data = '0; uart_ins_done = 1'b0;
      uart_data_wrEn = 1'b0; uart_data_addr = '0; uart_data_in = '0; uart_data_done = 1'b0;
      proc_dataMemWrEn = 1'b0; proc_dataMemAddr = '0; proc_dataOut = '0;
      proc_insMemAddr = '0; proc_done = 1'b0; result_base = '0; result_count = '0;
      busIf.tx_ready = 1'b1;
      repeat (3) tick();
      checkVal("rst_state", 32'(state), 32'd0);
      checkVal("rst_proc_startN", 32'(proc_startN), 32'd1);
      checkVal("rst_tx_valid", 32'(busIf.tx_valid), 32'd0);
      checkVal("rst_run_done", 32'(run_done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Full run
      doStart();
      for (int i = 0; i < 4; i++) insWrite(8'(i), 8'(8'h11 + i));
      insDone();
      dataWrite(12'h000, 12'hABC);
      dataWrite(12'h001, 12'h123);
      dataDone();
      procPhase(12'h000, 12'd2, 20, 1'b0, 1'b0);
      waitFinish();
      for (int i = 0; i < 4; i++) checkVal("ins_ram", 32'(insRam[i]), 32'(8'h11 + i));

      // Stray events and back-pressure
      doStart();
      uart_data_wrEn = 1'b1; uart_data_addr = 12'h007; uart_data_in = 12'hBAD;
      uart_data_done = 1'b1;
      tick();
      uart_data_wrEn = 1'b0; uart_data_done = 1'b0;
      checkVal("stray_data_done", 32'(state), 32'd1);
      insDone();
      dataWrite(12'h009, 12'h3C3);
      dataDone();
      busIf.tx_ready = 1'b0;
      procPhase(12'h009, 12'd2, 10, 1'b1, 1'b1);
      waitTxValid();
      checkVal("bp_addr0", 32'(busIf.dataMemAddr), 32'h009);
      for (int k = 0; k < 5; k++) begin
         tick();
         checkVal("bp_valid", 32'(busIf.tx_valid), 32'd1);
         checkVal("bp_data", 32'(busIf.tx_data), 32'h3C3);
      end
      checkVal("bp_addr_hold", 32'(busIf.dataMemAddr), 32'h009);
      busIf.tx_ready = 1'b1;
      tick();
      checkVal("bp_valid_drop", 32'(busIf.tx_valid), 32'd0);
      checkVal("bp_addr1", 32'(busIf.dataMemAddr), 32'h00A);
      waitFinish();
      checkVal("stray_ram", 32'(dataRam[7]), 32'd0);

      // Zero results
      doStart();
      insDone();
      dataDone();
      procPhase(12'h000, 12'd0, 5, 1'b0, 1'b0);
      checkVal("zero_direct_finish", 32'(state), 32'd6);
      waitFinish();
      checkVal("zero_no_tx", 32'(txSeen), 32'd0);

      // Address wrap-around
      doStart();
      insDone();
      dataWrite(12'hFFF, 12'h7E1);
      dataWrite(12'h000, 12'h0A5);
      dataDone();
      procPhase(12'hFFF, 12'd2, 6, 1'b0, 1'b0);
      checkVal("wrap_addr0", 32'(busIf.dataMemAddr), 32'hFFF);
      waitFinish();

      // Asynchronous reset mid-unload
      doStart();
      insDone();
      dataDone();
      busIf.tx_ready = 1'b0;
      procPhase(12'h000, 12'd3, 4, 1'b0, 1'b0);
      waitTxValid();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkVal("arst_state", 32'(state), 32'd0);
      checkVal("arst_tx_valid", 32'(busIf.tx_valid), 32'd0);
      checkVal("arst_tx_data", 32'(busIf.tx_data), 32'd0);
      checkVal("arst_addr", 32'(busIf.dataMemAddr), 32'd0);
      checkVal("arst_proc_startN", 32'(proc_startN), 32'd1);
      expQ.delete();
      @(negedge clk);
      rst = 1'b0;
      busIf.tx_ready = 1'b1;
      tick();
      doStart();
      insDone();
      dataDone();
      procPhase(12'h000, 12'd0, 3, 1'b0, 1'b0);
      waitFinish();

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
